// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BIN_W_MIN = 4;
    localparam int BIN_W_MAX = 32;
    localparam int CNT_W_MAX = $clog2(BIN_W_MAX + 1);

    // Decimal digits needed to represent 2^bin_w - 1.
    function automatic int min_digits(input int bin_w);
        longint unsigned v;
        int              n;
        v = (64'd1 << bin_w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: a digit of 5 or more gets +3 before the next shift.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: one operand bit per clock, packed BCD out.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// CONV  | one shift/adjust step per cycle, BIN_W cycles
// DONE  | publish scratch digits and sign, pulse out_valid
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  busy
);

    localparam int DIG_W = 4 * DIGITS;
    localparam int CAT_W = DIG_W + BIN_W;
    localparam int CNT_W = cnt_width(BIN_W);

    generate
        if (BIN_W < BIN_W_MIN || BIN_W > BIN_W_MAX) begin : g_bad_bin_w
            $error("bin2bcd_seq: BIN_W=%0d outside %0d..%0d", BIN_W, BIN_W_MIN, BIN_W_MAX);
        end
        if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS=%0d too small, need %0d for BIN_W=%0d",
                   DIGITS, min_digits(BIN_W), BIN_W);
        end
    endgenerate

    state_t             r_state;
    logic [BIN_W-1:0]   r_shift;
    logic [DIG_W-1:0]   r_digits;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_pend;
    logic [DIG_W-1:0]   r_bcd;
    logic               r_neg;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_in_ready;

    logic               w_sign;
    logic [BIN_W-1:0]   w_neg_bin;
    logic [BIN_W-1:0]   w_mag;
    logic [DIG_W-1:0]   w_adj;
    logic [CAT_W-1:0]   w_cat;

    // Negating -2^(BIN_W-1) wraps to 2^(BIN_W-1) as unsigned, which is the wanted magnitude.
    assign w_sign    = SIGNED & bin[BIN_W-1];
    assign w_neg_bin = {BIN_W{1'b0}} - bin;
    assign w_mag     = w_sign ? w_neg_bin : bin;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_digits[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    assign w_cat = {w_adj, r_shift} << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_digits    <= '0;
            r_cnt       <= '0;
            r_neg_pend  <= 1'b0;
            r_bcd       <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift    <= w_mag;
                        r_digits   <= '0;
                        r_neg_pend <= w_sign;
                        r_cnt      <= CNT_W'(BIN_W);
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_digits <= w_cat[CAT_W-1:BIN_W];
                    r_shift  <= w_cat[BIN_W-1:0];
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd       <= r_digits;
                    r_neg       <= r_neg_pend;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;
    assign neg       = r_neg;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 8-bit unsigned, 16-bit/5-digit unsigned and 8-bit signed instances.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv0, rdy0, ov0, neg0, busy0;
    logic [7:0]  bin0;
    logic [11:0] bcd0;

    logic        iv1, rdy1, ov1, neg1, busy1;
    logic [15:0] bin1;
    logic [19:0] bcd1;

    logic        iv2, rdy2, ov2, neg2, busy2;
    logic [7:0]  bin2;
    logic [11:0] bcd2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .bin(bin0),
        .out_valid(ov0), .bcd(bcd0), .neg(neg0), .busy(busy0)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .bin(bin1),
        .out_valid(ov1), .bcd(bcd1), .neg(neg1), .busy(busy1)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut_s8 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .bin(bin2),
        .out_valid(ov2), .bcd(bcd2), .neg(neg2), .busy(busy2)
    );

    task automatic set_in(input int d, input logic v, input logic [15:0] x);
        case (d)
            0:       begin iv0 = v; bin0 = x[7:0]; end
            1:       begin iv1 = v; bin1 = x;      end
            default: begin iv2 = v; bin2 = x[7:0]; end
        endcase
    endtask

    task automatic sample(input int d, output logic ov, output logic rdy, output logic [19:0] b);
        case (d)
            0:       begin ov = ov0; rdy = rdy0; b = {8'h00, bcd0}; end
            1:       begin ov = ov1; rdy = rdy1; b = bcd1;          end
            default: begin ov = ov2; rdy = rdy2; b = {8'h00, bcd2}; end
        endcase
    endtask

    // Returns right after the accept edge.
    task automatic start(input int d, input logic [15:0] x);
        @(negedge clk);
        set_in(d, 1'b1, x);
        @(posedge clk);
    endtask

    // k counts edges since accept; inputs are replaced by (nv, nb) at k==0.
    task automatic wait_result(input int d, input logic nv, input logic [15:0] nb,
                               output int lat, output int n_rdy, output int n_bcd_chg);
        logic        ov, rdy;
        logic [19:0] b, b0;
        lat = -1; n_rdy = 0; n_bcd_chg = 0; b0 = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) set_in(d, nv, nb);
            sample(d, ov, rdy, b);
            if (k == 0) b0 = b;
            if (ov) begin
                lat = k;
                break;
            end
            if (rdy) n_rdy++;
            if (b !== b0) n_bcd_chg++;
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        set_in(0, 1'b0, 16'h0); set_in(1, 1'b0, 16'h0); set_in(2, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        checks++;
        if ({ov0, busy0, neg0, bcd0} !== 15'h0) begin
            errors++; $display("FAIL reset_dut8: got ov/busy/neg/bcd=%h required 0", {ov0, busy0, neg0, bcd0});
        end
        checks++;
        if ({ov1, busy1, neg1, bcd1} !== 23'h0) begin
            errors++; $display("FAIL reset_dut16: got ov/busy/neg/bcd=%h required 0", {ov1, busy1, neg1, bcd1});
        end
        checks++;
        if ({ov2, busy2, neg2, bcd2} !== 15'h0) begin
            errors++; $display("FAIL reset_dut_s8: got ov/busy/neg/bcd=%h required 0", {ov2, busy2, neg2, bcd2});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1, rdy2} !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready: got %b required 111", {rdy0, rdy1, rdy2});
        end
    endtask

    task automatic test_max_8;
        int lat, nr, nc;
        start(0, 16'd255);
        wait_result(0, 1'b0, 16'd255, lat, nr, nc);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL max8_latency: got %0d required 9", lat); end
        checks++;
        if (bcd0 !== 12'h255) begin errors++; $display("FAIL max8_bcd: got %h required 255", bcd0); end
        checks++;
        if (neg0 !== 1'b0) begin errors++; $display("FAIL max8_neg: got %b required 0", neg0); end
        checks++;
        if (nr !== 0) begin errors++; $display("FAIL max8_in_ready_low: got %0d high cycles required 0", nr); end
        checks++;
        if (busy0 !== 1'b0 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL max8_idle_after: got busy=%b rdy=%b required busy=0 rdy=1", busy0, rdy0);
        end
    endtask

    task automatic test_back_to_back;
        int lat, nr, nc;
        start(0, 16'd0);
        wait_result(0, 1'b1, 16'd99, lat, nr, nc);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL b2b_first_latency: got %0d required 9", lat); end
        checks++;
        if (bcd0 !== 12'h000) begin errors++; $display("FAIL b2b_first_bcd: got %h required 000", bcd0); end
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_valid: got %b required 1", rdy0); end
        @(posedge clk);
        wait_result(0, 1'b0, 16'd99, lat, nr, nc);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL b2b_second_latency: got %0d required 9", lat); end
        checks++;
        if (nc !== 0) begin errors++; $display("FAIL b2b_bcd_hold: got %0d changed cycles required 0", nc); end
        checks++;
        if (bcd0 !== 12'h099) begin errors++; $display("FAIL b2b_second_bcd: got %h required 099", bcd0); end
    endtask

    task automatic test_wide_16;
        int lat, nr, nc;
        start(1, 16'hFFFF);
        wait_result(1, 1'b0, 16'hFFFF, lat, nr, nc);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL w16_latency: got %0d required 17", lat); end
        checks++;
        if (bcd1 !== 20'h65535) begin errors++; $display("FAIL w16_max_bcd: got %h required 65535", bcd1); end
        start(1, 16'd10000);
        wait_result(1, 1'b0, 16'd10000, lat, nr, nc);
        checks++;
        if (bcd1 !== 20'h10000 || lat !== 17) begin
            errors++; $display("FAIL w16_10000: got bcd=%h lat=%0d required bcd=10000 lat=17", bcd1, lat);
        end
        checks++;
        if (neg1 !== 1'b0) begin errors++; $display("FAIL w16_neg: got %b required 0", neg1); end
    endtask

    task automatic test_signed;
        logic [7:0]  vin  [4] = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        logic [11:0] vbcd [4] = '{12'h128, 12'h001, 12'h127, 12'h000};
        logic        vneg [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat, nr, nc;
        for (int i = 0; i < 4; i++) begin
            start(2, {8'h00, vin[i]});
            wait_result(2, 1'b0, {8'h00, vin[i]}, lat, nr, nc);
            checks++;
            if (bcd2 !== vbcd[i] || neg2 !== vneg[i] || lat !== 9) begin
                errors++;
                $display("FAIL signed_%h: got bcd=%h neg=%b lat=%0d required bcd=%h neg=%b lat=9",
                         vin[i], bcd2, neg2, lat, vbcd[i], vneg[i]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int lat, extra;
        start(0, 16'd200);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ov0) begin
                lat = k;
                break;
            end
            iv0  = (k < 8 && (k % 2) == 0) ? 1'b1 : 1'b0;
            bin0 = 8'($urandom);
            @(posedge clk);
        end
        iv0 = 1'b0;
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL busy_latency: got %0d required 9", lat); end
        checks++;
        if (bcd0 !== 12'h200) begin errors++; $display("FAIL busy_bcd: got %h required 200", bcd0); end
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (ov0) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL busy_single_pulse: got %0d extra pulses required 0", extra); end
        checks++;
        if (bcd0 !== 12'h200) begin errors++; $display("FAIL busy_bcd_hold: got %h required 200", bcd0); end
    endtask

    task automatic test_reset_mid;
        int lat, nr, nc, pulses;
        start(0, 16'd123);
        @(negedge clk);
        set_in(0, 1'b0, 16'd123);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ov0, busy0, neg0, bcd0} !== 15'h0) begin
            errors++; $display("FAIL midrst_outputs: got ov/busy/neg/bcd=%h required 0", {ov0, busy0, neg0, bcd0});
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (ov0) pulses++;
        end
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ov0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d pulses required 0", pulses); end
        checks++;
        if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got rdy=%b busy=%b required rdy=1 busy=0", rdy0, busy0);
        end
        start(0, 16'd45);
        wait_result(0, 1'b0, 16'd45, lat, nr, nc);
        checks++;
        if (bcd0 !== 12'h045 || lat !== 9) begin
            errors++; $display("FAIL midrst_after: got bcd=%h lat=%0d required bcd=045 lat=9", bcd0, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_max_8();
        test_back_to_back();
        test_wide_16();
        test_signed();
        test_ignore_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
